event_window_tx: RTL

Transmit-side front end for the graph builder. It accepts raw DVS events (sensor coordinates plus an absolute microsecond timestamp) over a valid/ready handshake. It slices the stream into fixed-length time windows, quantizes each event's in-window time to `GRAPH_BIT_WIDTH` bits, and emits packed `event_type` records through an output FIFO. An end-of-window marker is inserted between windows. It drives the event input of the graph generator, which consumes `event_type` {x, y, t, p, valid}.

---
 rtl/event_window_tx.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/event_window_tx.sv
// event_window_tx
// ---------------------------------------------------------------------------
// Transmit-side front end for the graph builder.
//
// Raw DVS events (x, y, absolute timestamp, polarity) come in over a
// valid/ready handshake. The module slices the stream into fixed-length time
// windows. Each event's in-window time is quantized to GRAPH_BIT_WIDTH bits,
// and the event is emitted as a packed record through an output FIFO whose
// head is registered. An end-of-window marker separates windows.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_x, in_y          sensor coordinates (IN_COORD_WIDTH)
//   in_ts               absolute timestamp (TS_WIDTH, wraps)
//   in_p                polarity
//   win_flush           pulse that closes the current window
//   out_valid/out_ready output handshake (FIFO head)
//   out_event           packed {x, y, t, p, valid}
//   out_eow             head entry is an end-of-window marker
//   drop_count          saturating count of out-of-range events dropped
//
// Build option
//   EVENT_TX_ROI_CHECK_EN  when defined, events with x or y outside the graph
//                          are consumed but dropped and counted. Otherwise
//                          coordinates are truncated and every event is kept.
// ---------------------------------------------------------------------------
module event_window_tx #(
    parameter int GRAPH_SIZE      = 256,
    parameter int TIME_WINDOW     = 50000,
    parameter int TS_WIDTH        = 32,
    parameter int IN_COORD_WIDTH  = 9,
    parameter int FIFO_DEPTH      = 16,
    parameter int GRAPH_BIT_WIDTH = $clog2(GRAPH_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_COORD_WIDTH-1:0]    in_x,
    input  logic [IN_COORD_WIDTH-1:0]    in_y,
    input  logic [TS_WIDTH-1:0]          in_ts,
    input  logic                         in_p,
    input  logic                         win_flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3*GRAPH_BIT_WIDTH+1:0] out_event,
    output logic                         out_eow,
    output logic [15:0]                  drop_count
);

    localparam int GBW = GRAPH_BIT_WIDTH;
    localparam int EW  = 3 * GBW + 2;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int PRW = TS_WIDTH + 25;
    localparam logic [24:0]         RECIP  = 25'((64'(GRAPH_SIZE) << 24) / 64'(TIME_WINDOW));
    localparam logic [TS_WIDTH-1:0] TW_L   = TS_WIDTH'(TIME_WINDOW);
    localparam logic [TS_WIDTH:0]   TMAX_L = (TS_WIDTH + 1)'(GRAPH_SIZE - 1);
    localparam logic [CW:0]         LIMIT  = (CW + 1)'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CLOSE  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [TS_WIDTH-1:0] t0_r;
    logic                flush_pending_r;

    logic                s1_valid_r, s1_eow_r, s1_p_r;
    logic [TS_WIDTH-1:0] s1_dt_r;
    logic [GBW-1:0]      s1_x_r, s1_y_r;
    logic                s2_valid_r;
    logic [EW:0]         s2_rec_r;

    logic [EW:0]         mem_r [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]       count_r;
    logic                head_valid_r;
    logic [EW:0]         head_rec_r;

    logic [TS_WIDTH-1:0] dt_s, enq_dt_s;
    logic [CW:0]         occ_s;
    logic                space_ok_s, in_range_s, flush_req_s, crossing_s;
    logic                in_ready_s, enq_s, marker_s, open_s, close_s;
    logic [PRW-1:0]      prod_s;
    logic [TS_WIDTH:0]   tq_s;
    logic [GBW-1:0]      t_s;
    logic [EW:0]         rec_s;
    logic                head_load_s, pop_s, bypass_s, push_s;
    logic                unused_bits_s;

    assign dt_s = in_ts - t0_r;
    // Everything already committed downstream counts against FIFO space, so
    // the pipeline never has to stall and a marker always finds room.
    assign occ_s = (CW + 1)'(count_r) + (CW + 1)'(head_valid_r)
                 + (CW + 1)'(s1_valid_r) + (CW + 1)'(s2_valid_r);
    assign space_ok_s  = (occ_s < LIMIT);
    assign flush_req_s = win_flush | flush_pending_r;

`ifdef EVENT_TX_ROI_CHECK_EN
    localparam logic [IN_COORD_WIDTH:0] GS_L = (IN_COORD_WIDTH + 1)'(GRAPH_SIZE);
    assign in_range_s    = ({1'b0, in_x} < GS_L) && ({1'b0, in_y} < GS_L);
    assign unused_bits_s = ^prod_s[23:0];
`else
    assign in_range_s    = 1'b1;
    assign unused_bits_s = ^{prod_s[23:0], in_x[IN_COORD_WIDTH-1:GBW], in_y[IN_COORD_WIDTH-1:GBW]};
`endif

    // A dropped (out-of-range) event never closes a window.
    assign crossing_s = in_valid & in_range_s & (dt_s >= TW_L);

    // Window FSM: next state, input ready and pipeline injection.
    always_comb begin
        state_s    = state_r;
        in_ready_s = 1'b0;
        enq_s      = 1'b0;
        marker_s   = 1'b0;
        open_s     = 1'b0;
        close_s    = 1'b0;
        enq_dt_s   = dt_s;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = space_ok_s;
                enq_dt_s   = {TS_WIDTH{1'b0}};
                if (in_valid && space_ok_s && in_range_s) begin
                    enq_s   = 1'b1;
                    open_s  = 1'b1;
                    state_s = ST_ACTIVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (flush_req_s) begin
                    close_s = 1'b1;
                    state_s = ST_CLOSE;
                end else if (crossing_s) begin
                    // The late event is refused and the marker goes in this
                    // very cycle, so the crossing costs a single input slot;
                    // the held event then opens the next window from IDLE.
                    marker_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    in_ready_s = space_ok_s;
                    enq_s      = in_valid & space_ok_s & in_range_s;
                    state_s    = ST_ACTIVE;
                end
            end
            ST_CLOSE: begin
                marker_s = 1'b1;
                state_s  = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign in_ready = in_ready_s & ~rst;

    // FSM state, window origin and pending-flush flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            t0_r            <= {TS_WIDTH{1'b0}};
            flush_pending_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (open_s) begin
                t0_r <= in_ts;
            end
            if (close_s) begin
                flush_pending_r <= 1'b0;
            end else if (win_flush && (state_r != ST_IDLE)) begin
                flush_pending_r <= 1'b1;
            end
        end
    end

    // Stage 1: capture in-window time and truncated fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_eow_r   <= 1'b0;
            s1_dt_r    <= {TS_WIDTH{1'b0}};
            s1_x_r     <= {GBW{1'b0}};
            s1_y_r     <= {GBW{1'b0}};
            s1_p_r     <= 1'b0;
        end else begin
            s1_valid_r <= enq_s | marker_s;
            s1_eow_r   <= marker_s;
            s1_dt_r    <= enq_dt_s;
            s1_x_r     <= in_x[GBW-1:0];
            s1_y_r     <= in_y[GBW-1:0];
            s1_p_r     <= in_p;
        end
    end

    assign prod_s = PRW'(s1_dt_r) * PRW'(RECIP);
    assign tq_s   = prod_s[PRW-1:24];

    // Quantize, saturate and pack the stage-2 record.
    always_comb begin
        t_s   = {GBW{1'b0}};
        rec_s = {(EW + 1){1'b0}};
        if (tq_s > TMAX_L) begin
            t_s = GBW'(GRAPH_SIZE - 1);
        end else begin
            t_s = tq_s[GBW-1:0];
        end
        if (s1_eow_r) begin
            rec_s = {1'b1, {EW{1'b0}}};
        end else begin
            rec_s = {1'b0, s1_x_r, s1_y_r, t_s, s1_p_r, 1'b1};
        end
    end

    // Stage 2: quantized record register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_rec_r   <= {(EW + 1){1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_rec_r   <= rec_s;
        end
    end

    // The head register refills whenever it is empty or being consumed; the
    // stage-2 record bypasses the array only when the array holds nothing.
    assign head_load_s = ~head_valid_r | out_ready;
    assign pop_s       = head_load_s & (count_r != {CW{1'b0}});
    assign bypass_s    = head_load_s & (count_r == {CW{1'b0}}) & s2_valid_r;
    assign push_s      = s2_valid_r & ~bypass_s;

    // FIFO storage array.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s2_rec_r;
        end
    end

    // FIFO pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            head_valid_r <= 1'b0;
            head_rec_r   <= {(EW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
            if (head_load_s) begin
                if (pop_s) begin
                    head_valid_r <= 1'b1;
                    head_rec_r   <= mem_r[rd_ptr_r];
                end else if (s2_valid_r) begin
                    head_valid_r <= 1'b1;
                    head_rec_r   <= s2_rec_r;
                end else begin
                    head_valid_r <= 1'b0;
                    head_rec_r   <= {(EW + 1){1'b0}};
                end
            end
        end
    end

    assign out_valid = head_valid_r;
    assign out_event = head_rec_r[EW-1:0];
    assign out_eow   = head_rec_r[EW];

`ifdef EVENT_TX_ROI_CHECK_EN
    logic [15:0] drop_count_r;

    // Saturating count of consumed-but-dropped events.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_r <= 16'd0;
        end else if (in_valid && in_ready && !in_range_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'd1;
        end
    end

    assign drop_count = drop_count_r;
`else
    assign drop_count = 16'd0;
`endif

endmodule
